// File: rtl/serial_ripple_adder.sv
// Digit-serial unsigned adder: {Cout, R} = A + B, W bits per clock, LSB digit first,
// with a single registered carry between digits.
module serial_ripple_adder #(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] R,
    output logic         Cout,
    output logic         busy
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    generate
        if (W < 1 || W > N || (N % W) != 0) begin : g_bad_width
            $error("serial_ripple_adder: W must divide N evenly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  sum_sh;
    logic [N-1:0]  sum_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [W:0]    s;
    logic          accept;
    logic          last;
    logic          drain;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds in_valid (and A/B) until in_ready; a result stays presented
    // with out_valid high until the consumer raises out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;
    assign last   = (state == RUN) && (cnt == CW'(D - 1));

    always_comb begin
        s        = {1'b0, a_sh[W-1:0]} + {1'b0, b_sh[W-1:0]} + (W + 1)'(carry);
        // New digit enters at the top so that after D shifts digit 0 sits at bit 0.
        sum_next = (sum_sh >> W) | (N'(s[W-1:0]) << (N - W));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = DONE;
            DONE:    if (drain)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            R      <= '0;
            Cout   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh  <= A;
                b_sh  <= B;
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> W;
                b_sh   <= b_sh >> W;
                sum_sh <= sum_next;
                carry  <= s[W];
                cnt    <= cnt + CW'(1);
                if (last) begin
                    R    <= sum_next;
                    Cout <= s[W];
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed bench for serial_ripple_adder: N=8 at W=1 and W=4, plus N=16 lanes at W=1,2,4,8.
module tb_serial_ripple_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv1, ir1, ov1, or1, c1, busy1;
    logic [7:0] a1, b1, r1;

    logic       iv4, ir4, ov4, or4, c4, busy4;
    logic [7:0] a4, b4, r4;

    logic [15:0]      a16, b16;
    logic [3:0]       iv16, ir16, ov16, or16, c16, busy16;
    logic [3:0][15:0] r16;

    int checks = 0;
    int errors = 0;

    serial_ripple_adder #(.N(8), .W(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(or1), .R(r1), .Cout(c1), .busy(busy1)
    );

    serial_ripple_adder #(.N(8), .W(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .R(r4), .Cout(c4), .busy(busy4)
    );

    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
            serial_ripple_adder #(.N(16), .W(1 << g)) u_dut (
                .clk(clk), .rst_n(rst_n), .in_valid(iv16[g]), .in_ready(ir16[g]),
                .A(a16), .B(b16), .out_valid(ov16[g]), .out_ready(or16[g]),
                .R(r16[g]), .Cout(c16[g]), .busy(busy16[g])
            );
        end
    endgenerate

    // Reference ripple-borrow subtractor used for the R - B == A round trip.
    function automatic logic [15:0] ripple_sub(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        logic        bw;
        bw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d[i] = x[i] ^ y[i] ^ bw;
            bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
        end
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d1(input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic c, output int lat);
        int n;
        n   = 0;
        lat = -1;
        r   = 8'h00;
        c   = 1'b0;
        iv1 = 1'b1; a1 = a; b1 = b; or1 = 1'b1;
        while (!ir1 && n < 50) begin tick(); n++; end
        tick();
        iv1 = 1'b0; a1 = ~a; b1 = ~b;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ov1) begin lat = k; break; end
        end
        if (lat > 0) begin
            r = r1; c = c1;
            tick();
        end
    endtask

    task automatic drive_d4(input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic c, output int lat);
        int n;
        n   = 0;
        lat = -1;
        r   = 8'h00;
        c   = 1'b0;
        iv4 = 1'b1; a4 = a; b4 = b; or4 = 1'b1;
        while (!ir4 && n < 50) begin tick(); n++; end
        tick();
        iv4 = 1'b0; a4 = ~a; b4 = ~b;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ov4) begin lat = k; break; end
        end
        if (lat > 0) begin
            r = r4; c = c4;
            tick();
        end
    endtask

    task automatic drive_lanes(input logic [15:0] a, input logic [15:0] b,
                               output logic [3:0][15:0] r, output logic [3:0] c,
                               output logic timeout);
        int n;
        iv16 = 4'h0; or16 = 4'h0;
        repeat ($urandom_range(0, 3)) tick();
        a16 = a; b16 = b; iv16 = 4'hF;
        n = 0;
        while (ir16 != 4'hF && n < 50) begin tick(); n++; end
        tick();
        iv16 = 4'h0; a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (ov16 != 4'hF && n < 40) begin tick(); n++; end
        timeout = (ov16 != 4'hF);
        repeat ($urandom_range(0, 3)) tick();
        r = r16; c = c16;
        or16 = 4'hF;
        tick();
        or16 = 4'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        iv4 = 1'b0; or4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
        iv16 = 4'h0; or16 = 4'h0; a16 = 16'h0; b16 = 16'h0;
        tick();
        iv1 = 1'b1; a1 = 8'h5A; b1 = 8'h11;
        tick();
        checks++; if (ir1 !== 1'b1)   begin errors++; $display("FAIL reset_in_valid_ready got %b exp 1", ir1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_in_valid_busy got %b exp 0", busy1); end
        iv1 = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov1); end
        checks++; if (r1 !== 8'h00)   begin errors++; $display("FAIL reset_r got %h exp 00", r1); end
        checks++; if (c1 !== 1'b0)    begin errors++; $display("FAIL reset_cout got %b exp 0", c1); end
        checks++; if (ir4 !== 1'b1)   begin errors++; $display("FAIL reset_w4_ready got %b exp 1", ir4); end
        checks++; if (ir16 !== 4'hF)  begin errors++; $display("FAIL reset_lanes_ready got %h exp F", ir16); end
        checks++; if (busy16 !== 4'h0) begin errors++; $display("FAIL reset_lanes_busy got %h exp 0", busy16); end
    endtask

    task automatic test_basic;
        logic [7:0] r; logic c; int lat;
        drive_d1(8'h3C, 8'h0F, r, c, lat);
        checks++; if (lat !== 8)      begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
        checks++; if (r !== 8'h4B)    begin errors++; $display("FAIL basic_r got %h exp 4b", r); end
        checks++; if (c !== 1'b0)     begin errors++; $display("FAIL basic_cout got %b exp 0", c); end
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL basic_valid_one_cycle got %b exp 0", ov1); end
        checks++; if (ir1 !== 1'b1)   begin errors++; $display("FAIL basic_ready_return got %b exp 1", ir1); end
    endtask

    task automatic test_carry_chain;
        logic [7:0] r; logic c; int lat;
        drive_d1(8'hFF, 8'h01, r, c, lat);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL carry_r got %h exp 00", r); end
        checks++; if (c !== 1'b1)  begin errors++; $display("FAIL carry_cout got %b exp 1", c); end
        drive_d1(8'h00, 8'h00, r, c, lat);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL noleak_r got %h exp 00", r); end
        checks++; if (c !== 1'b0)  begin errors++; $display("FAIL noleak_cout got %b exp 0", c); end
    endtask

    task automatic test_w4;
        logic [7:0] r; logic c; int lat;
        drive_d4(8'h9A, 8'h77, r, c, lat);
        checks++; if (lat !== 2)   begin errors++; $display("FAIL w4_latency got %0d exp 2", lat); end
        checks++; if (r !== 8'h11) begin errors++; $display("FAIL w4_r got %h exp 11", r); end
        checks++; if (c !== 1'b1)  begin errors++; $display("FAIL w4_cout got %b exp 1", c); end
    endtask

    task automatic test_backpressure;
        int n;
        iv1 = 1'b1; a1 = 8'h12; b1 = 8'h34; or1 = 1'b0;
        tick();
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 40) begin tick(); n++; end
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_done_timeout got %b exp 1", ov1); end
        iv1 = 1'b1; a1 = 8'hAA; b1 = 8'h55;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", ov1); end
            checks++; if (r1 !== 8'h46) begin errors++; $display("FAIL bp_hold_r got %h exp 46", r1); end
            checks++; if (c1 !== 1'b0)  begin errors++; $display("FAIL bp_hold_cout got %b exp 0", c1); end
            checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %b exp 0", ir1); end
            tick();
        end
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL bp_drain_valid got %b exp 0", ov1); end
        checks++; if (ir1 !== 1'b1)   begin errors++; $display("FAIL bp_drain_ready got %b exp 1", ir1); end
        tick();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bp_next_accept got %b exp 1", busy1); end
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 40) begin tick(); n++; end
        checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL bp_next_r got %h exp ff", r1); end
        checks++; if (c1 !== 1'b0)  begin errors++; $display("FAIL bp_next_cout got %b exp 0", c1); end
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [7:0] r; logic c; int lat;
        logic seen;
        iv1 = 1'b1; a1 = 8'h55; b1 = 8'h22; or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL midrst_valid got %b exp 0", ov1); end
        checks++; if (r1 !== 8'h00)   begin errors++; $display("FAIL midrst_r got %h exp 00", r1); end
        checks++; if (c1 !== 1'b0)    begin errors++; $display("FAIL midrst_cout got %b exp 0", c1); end
        checks++; if (ir1 !== 1'b1)   begin errors++; $display("FAIL midrst_ready got %b exp 1", ir1); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b exp 0", seen); end
        drive_d1(8'h80, 8'h80, r, c, lat);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL midrst_after_r got %h exp 00", r); end
        checks++; if (c !== 1'b1)  begin errors++; $display("FAIL midrst_after_cout got %b exp 1", c); end
    endtask

    task automatic test_lanes;
        logic [15:0] va [10] = '{16'h1234, 16'hFFFF, 16'h8000, 16'hABCD, 16'hF0F0,
                                 16'hFFFF, 16'h7FFF, 16'h0000, 16'hDEAD, 16'h5A5A};
        logic [15:0] vb [10] = '{16'h4321, 16'h0001, 16'h8000, 16'h1234, 16'h0F0F,
                                 16'hFFFF, 16'h0001, 16'h0000, 16'hBEEF, 16'hA5A6};
        logic [15:0] vr [10] = '{16'h5555, 16'h0000, 16'h0000, 16'hBE01, 16'hFFFF,
                                 16'hFFFE, 16'h8000, 16'h0000, 16'h9D9C, 16'h0000};
        logic        vc [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0][15:0] r;
        logic [3:0]       c;
        logic             to;
        for (int v = 0; v < 10; v++) begin
            drive_lanes(va[v], vb[v], r, c, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL lane_timeout vec %0d got %b exp 0", v, to); end
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (r[g] !== vr[v]) begin
                    errors++; $display("FAIL lane_r vec %0d w %0d got %h exp %h", v, 1 << g, r[g], vr[v]);
                end
                checks++;
                if (c[g] !== vc[v]) begin
                    errors++; $display("FAIL lane_cout vec %0d w %0d got %b exp %b", v, 1 << g, c[g], vc[v]);
                end
                checks++;
                if (ripple_sub(r[g], vb[v]) !== va[v]) begin
                    errors++;
                    $display("FAIL lane_roundtrip vec %0d w %0d got %h exp %h", v, 1 << g, ripple_sub(r[g], vb[v]), va[v]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_w4();
        test_backpressure();
        test_reset_mid_op();
        test_lanes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_ripple_adder.md
# serial_ripple_adder

Multi-cycle unsigned adder computing {Cout, R} = A + B, W bits per clock, LSB digit first, through one registered carry. It is the additive counterpart of the combinational ripple-carry subtractor. It serves area-constrained datapaths: it reconstructs A from a difference R = A - B, and it accumulates operands arriving over a valid/ready stream. Operands are captured on an input handshake and the result is presented on an output handshake.

## Interface
- N, default 8: operand and result width in bits.
- W, default 1: bits added per cycle. W must divide N evenly; elaboration fails otherwise. Run length is D = N/W cycles.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- in_valid  input  1  A and B are valid this cycle.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- A  input  N  augend, unsigned.
- B  input  N  addend, unsigned.
- out_valid  output  1  R and Cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- R  output  N  sum modulo 2^N, registered.
- Cout  output  1  carry out of bit N-1 (unsigned overflow), registered.
- busy  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: D digit cycles.
  - DONE: out_valid=1.
- IDLE -> RUN on in_valid && in_ready. On that edge:
  - A and B load into internal shift registers.
  - Carry register clears to 0.
  - Digit counter clears to 0.
- Each RUN cycle:
  - Form s = A_sh[W-1:0] + B_sh[W-1:0] + carry, W+1 bits wide.
  - s[W-1:0] shifts into the top of the sum shift register.
  - Carry is updated to s[W].
  - A_sh and B_sh shift right by W.
  - The counter increments.
- RUN -> DONE on the edge where the counter reaches D-1. On that edge:
  - R loads the full sum, including the final digit.
  - Cout loads the final carry.
- DONE -> IDLE on out_valid && out_ready.
- R and Cout change only on the RUN->DONE edge and on reset. They hold the last result in IDLE and RUN.
- A and B are ignored outside the accept edge. Changes to them during RUN do not affect the result.
- in_valid in RUN or DONE is not accepted. The producer must hold it until in_ready.
- out_ready while out_valid=0 is ignored.
- Reset mid-RUN or in DONE abandons the operation. No out_valid pulse is produced for it.

## Timing
- Reset (rst_n low at an edge):
  - state goes to IDLE.
  - out_valid=0, R=0, Cout=0, busy=0.
  - Carry, counter and shift registers go to 0.
  - in_ready=1 from the first cycle after the reset edge.
- Latency: operands accepted at edge 0 give out_valid=1 in the cycle after edge D. With N=8, W=1, that is 8 clocks.
- in_ready falls in the cycle after the accept edge.
- Throughput: at most one operation per D+2 cycles. There is no overlap between result drain and next accept.
- With out_ready held high, out_valid stays high exactly one cycle, and in_ready returns the cycle after.
- Backpressure: DONE is held indefinitely. R, Cout and out_valid stay stable, and in_ready stays 0.
- rst_n low in the same cycle as in_valid: reset wins and nothing is accepted.
- rst_n low in the same cycle as out_ready: reset wins. The state is IDLE either way.

## Test plan
- N=8, W=1, A=0x3C, B=0x0F, out_ready=1 -> R=0x4B, Cout=0. out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle.
- N=8, W=1, A=0xFF, B=0x01 -> R=0x00, Cout=1. This checks carry propagation through all 8 digits. Then A=0x00, B=0x00 -> R=0x00, Cout=0, so no carry leaks between operations.
- N=8, W=4, A=0x9A, B=0x77 -> R=0x11, Cout=1, with out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and keep in_valid=1 with new operands.
  - Required: R and Cout stable, out_valid=1, in_ready=0, no accept.
  - After the handshake, the new operands are accepted in the following IDLE cycle.
- Reset mid-op: pull rst_n low at RUN digit 3 for one edge.
  - Required: out_valid never asserts for that operation, and R=0, Cout=0, in_ready=1 next cycle.
  - A subsequent A=0x80, B=0x80 then gives R=0x00, Cout=1.
- Randomised run, 1000 operations, N=16, W in {1,2,4,8}, random in_valid and out_ready gaps.
  - Check {Cout,R} == A+B for every operation.
  - Check the inverse round-trip: feed each R with B into the ripple-carry subtractor and confirm it returns A.
